// File: rtl/wb_writer.sv
// ---------------------------------------------------------------------------
// wb_writer
// Write-back initiator for the 32x32 MIPS register file. Merges the ALU
// result stream (never stalled, strict priority) and the handshaked load
// stream into the register file's single registered write port. Load results
// wait in a small FIFO while the ALU owns the port. An ALU write kills older
// queued loads to the same register, which keeps write-after-write order.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   alu_valid/alu_addr/alu_data    ALU result stream
//   ld_valid/ld_ready/ld_addr/ld_data   load result stream (valid/ready)
//   write_en/write_addr/write_data registered register-file write port
//   busy                           load FIFO non-empty
//   byp_addr/byp_hit/byp_data      forwarding query of newest pending value
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : combinational forwarding search
//   undefined : byp_hit/byp_data tied to zero, no search logic
// ---------------------------------------------------------------------------
module wb_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          write_en,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data,
  output logic          busy,
  input  logic [AW-1:0] byp_addr,
  output logic          byp_hit,
  output logic [DW-1:0] byp_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    fifoAddr_q [DEPTH];
  logic [DW-1:0]    fifoData_q [DEPTH];
  logic [DEPTH-1:0] fifoValid_q, fifoValid_d;
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ldReady_q;
  logic             wen_q, wen_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             push, pop;

  // ld_ready is registered, so a full FIFO refuses a push even when it pops
  // in the same cycle.
  assign push = ld_valid && ldReady_q;
  assign pop  = !alu_valid && (count_q != '0);

  // Entry valid bits mean "occupied and not superseded". A matching ALU write
  // kills older entries; a load pushed in the same cycle is younger and is
  // set afterwards, so it survives.
  always_comb begin
    fifoValid_d = fifoValid_q;
    if (alu_valid && (alu_addr != '0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifoValid_q[i] && (fifoAddr_q[i] == alu_addr)) begin
          fifoValid_d[i] = 1'b0;
        end
      end
    end
    if (pop) begin
      fifoValid_d[rdPtr_q] = 1'b0;
    end
    if (push) begin
      fifoValid_d[wrPtr_q] = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Port arbitration: ALU first, then the FIFO head. Register $zero and
  // killed entries occupy their slot but never assert the write enable.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_valid) begin
      wen_d   = (alu_addr != '0);
      waddr_d = alu_addr;
      wdata_d = alu_data;
    end else if (pop) begin
      wen_d   = fifoValid_q[rdPtr_q] && (fifoAddr_q[rdPtr_q] != '0);
      waddr_d = fifoAddr_q[rdPtr_q];
      wdata_d = fifoData_q[rdPtr_q];
    end
  end

  // Control state and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifoValid_q <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      ldReady_q   <= 1'b0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      fifoValid_q <= fifoValid_d;
      count_q     <= count_d;
      ldReady_q   <= (count_d != CW'(DEPTH));
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr_q[wrPtr_q] <= ld_addr;
      fifoData_q[wrPtr_q] <= ld_data;
    end
  end

  assign ld_ready   = ldReady_q;
  assign busy       = (count_q != '0);
  assign write_en   = wen_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;

`ifdef WB_BYPASS_EN
  logic          bypHit;
  logic [DW-1:0] bypData;
  logic [PW-1:0] bypIdx;

  // Lowest priority is evaluated first so later matches overwrite it:
  // output stage, FIFO oldest to newest, then the incoming ALU result.
  always_comb begin
    bypHit  = 1'b0;
    bypData = '0;
    bypIdx  = '0;
    if (wen_q && (waddr_q == byp_addr)) begin
      bypHit  = 1'b1;
      bypData = wdata_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      bypIdx = rdPtr_q + PW'(k);
      if ((CW'(k) < count_q) && fifoValid_q[bypIdx] &&
          (fifoAddr_q[bypIdx] == byp_addr)) begin
        bypHit  = 1'b1;
        bypData = fifoData_q[bypIdx];
      end
    end
    if (alu_valid && (alu_addr == byp_addr)) begin
      bypHit  = 1'b1;
      bypData = alu_data;
    end
    if (byp_addr == '0) begin
      bypHit  = 1'b0;
      bypData = '0;
    end
  end

  assign byp_hit  = bypHit;
  assign byp_data = bypData;
`else
  logic unusedBypAddr;
  assign unusedBypAddr = ^byp_addr;
  assign byp_hit       = 1'b0;
  assign byp_data      = '0;
`endif

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back initiator for the 32x32 MIPS register file.
- Merges two result streams into the register file's single write port:
  - the ALU stream, which is never stalled;
  - the load stream, which is valid/ready handshaked.
- Drives registered write_en / write_addr / write_data.
- Buffers load results in a small FIFO while the ALU holds the port, and keeps write-after-write order correct.

Parameters:
- DEPTH, 4, load FIFO entries. Power of two, 2..16.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted when ld_valid & ld_ready.
- ld_addr  in  AW  load destination register.
- ld_data  in  DW  load data.
- write_en  out  1  register-file write enable.
- write_addr  out  AW  register-file write address.
- write_data  out  DW  register-file write data.
- busy  out  1  FIFO non-empty.
- byp_addr  in  AW  forwarding query address.
- byp_hit  out  1  newest pending value exists for byp_addr.
- byp_data  out  DW  that pending value.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers, count and all valid bits cleared.
  - write_en=0, write_addr=0, write_data=0, busy=0, byp_hit=0, byp_data=0.
  - ld_ready=0 while rst=1; ld_ready=1 from the first cycle after release.
  - Reset mid-operation discards all queued loads; nothing is written.
- Output stage: write_en/addr/data are registers, so a selected result appears 1 cycle after selection.
- Port arbitration each cycle, ALU has strict priority:
  - alu_valid=1: output stage loads the ALU result; the FIFO does not pop.
  - alu_valid=0 and FIFO non-empty: pop the head entry into the output stage.
  - otherwise write_en=0 next cycle; write_addr/write_data hold their previous values.
- Register $zero:
  - any result with address 0 yields write_en=0 in its slot;
  - a load to address 0 is still accepted and popped normally.
- Load FIFO:
  - ld_ready = !full, registered from the count, with no same-cycle pass-through;
  - when full, push is blocked even if a pop occurs that cycle;
  - push and pop in the same cycle leave the count unchanged;
  - pointers wrap modulo DEPTH.
- Latency:
  - ALU result: 1 cycle;
  - load into an empty FIFO with no ALU activity: accepted at edge N, popped at edge N+1, write_en=1 after edge N+1 (2 cycles).
- WAW ordering:
  - when alu_valid=1 and alu_addr (non-zero) matches any valid FIFO entry, those entries are killed by clearing their valid bits;
  - a killed entry still pops in order but produces write_en=0;
  - a load accepted in the same cycle as a matching ALU result is younger than it and is not killed.
- busy = count != 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: byp_hit/byp_data are combinational.
  - Search priority, highest first: incoming alu (alu_valid), newest valid FIFO entry, oldest valid FIFO entry, output stage (write_en).
  - byp_addr=0 always gives byp_hit=0.
- Undefined: byp_hit=0 and byp_data=0 constant; no search logic is built.

Test Plan:
- Reset release, then alu_valid=1, addr=3, data=32'h0000_00AA for one cycle -> next cycle write_en=1, write_addr=3, write_data=32'h0000_00AA; the following cycle write_en=0.
- ALU address 0, data 32'hFFFF_FFFF -> write_en stays 0 throughout.
- alu_valid held 1 for 6 cycles while offering 5 loads (addr 8..12) with DEPTH=4 -> 4 loads accepted, ld_ready=0 with the 5th pending, busy=1. After alu_valid drops: writes to 8, 9, 10, 11 on consecutive cycles, then the 5th (12) is accepted and written.
- Load addr 7, data 32'h1111 queued behind ALU traffic; then ALU addr 7, data 32'h2222 -> register 7 written once with 32'h2222; the load slot later shows write_en=0.
- rst pulsed while 3 loads are queued -> busy=0, write_en=0 immediately (async). After release, no queued write ever appears.
- With WB_BYPASS_EN: FIFO holds addr 5 = 32'hA, then addr 5 = 32'hB; byp_addr=5 -> byp_hit=1, byp_data=32'hB. Without the macro -> byp_hit=0.
